// File: rtl/uart_pkg.sv
// Shared types for the UART receive/transmit paths: FSM state encoding and parity modes.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: counts 0..div and pulses tick for one clk at div.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q >= div) begin
      cnt_d = '0;
      tick  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..D_W data bits, optional parity, 1/2 stop bits,
// majority-vote sampling, break detect and a valid/ready word output.
//
// state  | meaning
// IDLE   | waiting for a low synced line with cfg_en set
// START  | validating the start bit, glitches return to IDLE
// DATA   | sampling data bits LSB first
// PARITY | sampling the parity bit
// STOP   | checking stop bit(s); frame completes at the last decision point
// BREAK  | all-zero frame seen, waiting for the line to return high
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int D_W    = 9,
  parameter int B_TICK = 16,
  parameter int DIV_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_data,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [3:0]       cfg_dbits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  output logic [D_W-1:0]   rx_byte,
  output logic             rx_perr,
  output logic             rx_ferr,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             err_overrun,
  output logic             err_break,
  output logic             busy
);

  localparam int IW = $clog2(B_TICK);
  localparam logic [IW-1:0] I_S0  = IW'(B_TICK/2 - 1);
  localparam logic [IW-1:0] I_S1  = IW'(B_TICK/2);
  localparam logic [IW-1:0] I_DEC = IW'(B_TICK/2 + 1);
  localparam logic [IW-1:0] I_END = IW'(B_TICK - 1);
  localparam logic [3:0]    DMAX  = 4'(D_W);

  rx_state_t        state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [IW-1:0]    idx_q, idx_d;
  logic             s0_q, s0_d, s1_q, s1_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic [D_W-1:0]   sh_q, sh_d;
  logic             dpar_q, dpar_d;
  logic             perr_acc_q, perr_acc_d;
  logic             ferr_acc_q, ferr_acc_d;
  logic             zero_q, zero_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       dbits_q, dbits_d;
  logic [1:0]       par_q, par_d;
  logic             stop2_q, stop2_d;
  logic [D_W-1:0]   rx_byte_q, rx_byte_d;
  logic             rx_perr_q, rx_perr_d;
  logic             rx_ferr_q, rx_ferr_d;
  logic             rx_valid_q, rx_valid_d;
  logic             ovr_q, ovr_d;
  logic             brk_q, brk_d;

  logic rx_s, tick, maj, dec, bit_end, done, ferr_now, zero_now;

  assign rx_s = sync2_q;

  // Counter runs only while a frame is in progress, so each frame starts phase-aligned.
  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state_q == IDLE) || !cfg_en),
    .div   (div_q),
    .tick  (tick)
  );

  assign maj     = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign dec     = tick && (idx_q == I_DEC);
  assign bit_end = tick && (idx_q == I_END);

  always_comb begin
    idx_d = idx_q;
    if (state_q == IDLE)  idx_d = '0;
    else if (tick)        idx_d = (idx_q == I_END) ? '0 : idx_q + 1'b1;
    s0_d = (tick && idx_q == I_S0) ? rx_s : s0_q;
    s1_d = (tick && idx_q == I_S1) ? rx_s : s1_q;
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    sh_d       = sh_q;
    dpar_d     = dpar_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    zero_d     = zero_q;
    div_d      = div_q;
    dbits_d    = dbits_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    done       = 1'b0;
    brk_d      = 1'b0;
    ferr_now   = ferr_acc_q;
    zero_now   = zero_q;

    case (state_q)
      IDLE: begin
        if (cfg_en && !rx_s) begin
          state_d    = START;
          div_d      = cfg_div;
          dbits_d    = (cfg_dbits < 4'd5) ? 4'd5 : ((cfg_dbits > DMAX) ? DMAX : cfg_dbits);
          par_d      = cfg_parity;
          stop2_d    = cfg_stop2;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          sh_d       = '0;
          dpar_d     = 1'b0;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
          zero_d     = 1'b1;
        end
      end
      START: begin
        if (dec && maj)   state_d = IDLE;
        else if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (dec) begin
          if (bit_cnt_q < DMAX) sh_d[bit_cnt_q] = maj;
          dpar_d = dpar_q ^ maj;
          zero_d = zero_q & ~maj;
        end
        if (bit_end) begin
          if (bit_cnt_q == dbits_q - 4'd1)
            state_d = (par_q == PAR_EVEN || par_q == PAR_ODD) ? PARITY : STOP;
          else
            bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      PARITY: begin
        if (dec) begin
          perr_acc_d = (maj ^ dpar_q) != (par_q == PAR_ODD);
          zero_d     = zero_q & ~maj;
        end
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (dec) begin
          ferr_now   = ferr_acc_q | ~maj;
          zero_now   = zero_q & ~maj;
          ferr_acc_d = ferr_now;
          zero_d     = zero_now;
          if (stop_cnt_q == stop2_q) begin
            if (zero_now) begin
              state_d = BREAK;
              brk_d   = 1'b1;
            end else begin
              state_d = IDLE;
              done    = 1'b1;
            end
          end
        end
        if (bit_end) stop_cnt_d = 1'b1;
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!cfg_en) begin
      state_d = IDLE;
      done    = 1'b0;
      brk_d   = 1'b0;
    end
  end

  always_comb begin
    rx_byte_d  = rx_byte_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_valid_d = rx_valid_q;
    ovr_d      = 1'b0;
    if (done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_byte_d  = sh_q;
        rx_perr_d  = perr_acc_q;
        rx_ferr_d  = ferr_now;
        rx_valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      idx_q      <= '0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      sh_q       <= '0;
      dpar_q     <= 1'b0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      zero_q     <= 1'b0;
      div_q      <= '0;
      dbits_q    <= '0;
      par_q      <= PAR_NONE;
      stop2_q    <= 1'b0;
      rx_byte_q  <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= rx_data;
      sync2_q    <= sync1_q;
      idx_q      <= idx_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      sh_q       <= sh_d;
      dpar_q     <= dpar_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      zero_q     <= zero_d;
      div_q      <= div_d;
      dbits_q    <= dbits_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      rx_byte_q  <= rx_byte_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_valid_q <= rx_valid_d;
      ovr_q      <= ovr_d;
      brk_q      <= brk_d;
    end
  end

  assign rx_byte     = rx_byte_q;
  assign rx_perr     = rx_perr_q;
  assign rx_ferr     = rx_ferr_q;
  assign rx_valid    = rx_valid_q;
  assign err_overrun = ovr_q;
  assign err_break   = brk_q;
  assign busy        = (state_q != IDLE);

endmodule
